// File: rtl/mz_seq_pkg.sv
// Shared types and constants for the Mach-Zehnder pulse sequencer.
// The optional repeat feature is selected with MZ_SEQ_REPEAT_EN.
package mz_seq_pkg;

  localparam int CW_DEFAULT = 16;
  localparam int RW_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    PI2_A = 3'd2,
    GAP_1 = 3'd3,
    PI    = 3'd4,
    GAP_2 = 3'd5,
    PI2_B = 3'd6
  } mz_state_t;

  localparam logic [1:0] PIDX_NONE = 2'd0;
  localparam logic [1:0] PIDX_PI2A = 2'd1;
  localparam logic [1:0] PIDX_PI   = 2'd2;
  localparam logic [1:0] PIDX_PI2B = 2'd3;

  function automatic logic [1:0] pidx_of(mz_state_t s);
    case (s)
      PI2_A:   return PIDX_PI2A;
      PI:      return PIDX_PI;
      PI2_B:   return PIDX_PI2B;
      default: return PIDX_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mz_phase_timer.sv
// Loadable down-counter timing one sequencer phase; expired is high at zero.
// It never wraps: the count holds at zero until the next load.
module mz_phase_timer
  import mz_seq_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  localparam logic [CW-1:0] ONE = 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mz_pulse_sequencer.sv
// pi/2 - pi - pi/2 RF gate sequencer with latched run-time durations.
// Define MZ_SEQ_REPEAT_EN to add cfg_repeat / shot_cnt multi-shot operation.
module mz_pulse_sequencer
  import mz_seq_pkg::*;
#(
  parameter int CW = CW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig,
  input  logic [CW-1:0] cfg_delay,
  input  logic [CW-1:0] cfg_pi2_len,
  input  logic [CW-1:0] cfg_pi_len,
  input  logic [CW-1:0] cfg_interval,
`ifdef MZ_SEQ_REPEAT_EN
  input  logic [RW-1:0] cfg_repeat,
  output logic [RW-1:0] shot_cnt,
`endif
  output logic          rf,
  output logic [1:0]    pulse_idx,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam logic [CW-1:0] ONE   = 1;
  localparam logic [RW-1:0] ONE_R = 1;

  mz_state_t     state, state_nxt, seq_first;
  logic          start_q;
  logic [CW-1:0] sh_delay, sh_pi2, sh_pi, sh_int;
  logic [RW-1:0] rep_q, shot_q;
  logic          expired, load;
  logic [CW-1:0] load_val;
  logic          eligible, cfg_bad, start, reject, more_shots;
  logic          rf_d, busy_d, done_d;
  logic [1:0]    pidx_d;

  // trig is a level sampled every edge. It is accepted only in IDLE, with no
  // start pending and no done pulse on the output; otherwise it is dropped.
  assign eligible   = trig && (state == IDLE) && !start_q && !done;
  assign cfg_bad    = (cfg_pi2_len == '0) || (cfg_pi_len == '0);
  assign start      = eligible && !cfg_bad;
  assign reject     = eligible && cfg_bad;
  assign more_shots = (shot_q < rep_q);
  assign seq_first  = (sh_delay != '0) ? DELAY : PI2_A;

  mz_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      sh_delay <= '0;
      sh_pi2   <= '0;
      sh_pi    <= '0;
      sh_int   <= '0;
      shot_q   <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      if (start) begin
        sh_delay <= cfg_delay;
        sh_pi2   <= cfg_pi2_len;
        sh_pi    <= cfg_pi_len;
        sh_int   <= cfg_interval;
        shot_q   <= '0;
      end else if ((state == PI2_B) && expired && more_shots) begin
        shot_q <= shot_q + ONE_R;
      end
    end
  end

`ifdef MZ_SEQ_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else if (start) begin
      rep_q <= cfg_repeat;
    end
  end
  assign shot_cnt = shot_q;
`else
  assign rep_q = '0;
`endif

  // Zero-length delay and gap phases are skipped rather than entered.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_q) state_nxt = seq_first;
      DELAY:   if (expired) state_nxt = PI2_A;
      PI2_A:   if (expired) state_nxt = (sh_int != '0) ? GAP_1 : PI;
      GAP_1:   if (expired) state_nxt = PI;
      PI:      if (expired) state_nxt = (sh_int != '0) ? GAP_2 : PI2_B;
      GAP_2:   if (expired) state_nxt = PI2_B;
      PI2_B:   if (expired) state_nxt = more_shots ? seq_first : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load     = (state_nxt != state);
    load_val = '0;
    case (state_nxt)
      DELAY:         load_val = sh_delay - ONE;
      PI2_A, PI2_B:  load_val = sh_pi2 - ONE;
      PI:            load_val = sh_pi - ONE;
      GAP_1, GAP_2:  load_val = sh_int - ONE;
      default:       load_val = '0;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line
  // up with the state they describe.
  always_comb begin
    rf_d   = 1'b0;
    pidx_d = pidx_of(state_nxt);
    busy_d = (state_nxt != IDLE);
    done_d = (state == PI2_B) && (state_nxt == IDLE);
    if (pidx_d != PIDX_NONE) rf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf        <= 1'b0;
      pulse_idx <= PIDX_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      rf        <= rf_d;
      pulse_idx <= pidx_d;
      busy      <= busy_d;
      done      <= done_d;
      cfg_err   <= reject;
    end
  end

endmodule

// File: tb/tb_mz_pulse_sequencer.sv
// Bench for mz_pulse_sequencer: per-cycle timeline model built from durations.
// Repeat scenarios are included when MZ_SEQ_REPEAT_EN is defined.
module tb_mz_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [15:0] cfg_delay, cfg_pi2_len, cfg_pi_len, cfg_interval;
  logic        rf, busy, done, cfg_err;
  logic [1:0]  pulse_idx;
`ifdef MZ_SEQ_REPEAT_EN
  logic [7:0]  cfg_repeat;
  logic [7:0]  shot_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // {shot[7:0], done, busy, idx[1:0], rf} for the cycle after each edge
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  mz_pulse_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trig         (trig),
    .cfg_delay    (cfg_delay),
    .cfg_pi2_len  (cfg_pi2_len),
    .cfg_pi_len   (cfg_pi_len),
    .cfg_interval (cfg_interval),
`ifdef MZ_SEQ_REPEAT_EN
    .cfg_repeat   (cfg_repeat),
    .shot_cnt     (shot_cnt),
`endif
    .rf           (rf),
    .pulse_idx    (pulse_idx),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] pk(input logic r, input logic [1:0] idx, input logic b,
                                     input logic d, input int shot);
    logic [7:0] s;
    s = shot[7:0];
    return {s, d, b, idx, r};
  endfunction

  // Timeline: accept cycle, then per shot delay / pi2 / gap / pi / gap / pi2,
  // then one done cycle and one idle cycle.
  task automatic build(input int d, input int p2, input int i, input int p, input int rep);
    exp_q.delete();
    exp_q.push_back(pk(1'b0, 2'd0, 1'b0, 1'b0, 0));
    for (int s = 0; s <= rep; s++) begin
      repeat (d)  exp_q.push_back(pk(1'b0, 2'd0, 1'b1, 1'b0, s));
      repeat (p2) exp_q.push_back(pk(1'b1, 2'd1, 1'b1, 1'b0, s));
      repeat (i)  exp_q.push_back(pk(1'b0, 2'd0, 1'b1, 1'b0, s));
      repeat (p)  exp_q.push_back(pk(1'b1, 2'd2, 1'b1, 1'b0, s));
      repeat (i)  exp_q.push_back(pk(1'b0, 2'd0, 1'b1, 1'b0, s));
      repeat (p2) exp_q.push_back(pk(1'b1, 2'd3, 1'b1, 1'b0, s));
    end
    exp_q.push_back(pk(1'b0, 2'd0, 1'b0, 1'b1, rep));
    exp_q.push_back(pk(1'b0, 2'd0, 1'b0, 1'b0, rep));
  endtask

  task automatic set_cfg(input int d, input int p2, input int i, input int p, input int rep);
    cfg_delay    = d[15:0];
    cfg_pi2_len  = p2[15:0];
    cfg_interval = i[15:0];
    cfg_pi_len   = p[15:0];
`ifdef MZ_SEQ_REPEAT_EN
    cfg_repeat   = rep[7:0];
`else
    if (rep != 0) $display("note: repeat count ignored in single-shot build");
`endif
  endtask

  // noise: random trig and cfg values while the run is active (must be ignored).
  // stop_k >= 0 ends the run early, right after checking entry stop_k.
  task automatic run_seq(input int d, input int p2, input int i, input int p, input int rep,
                         input bit noise, input int stop_k, input string tag);
    logic [12:0] e;
    int n;
    set_cfg(d, p2, i, p, rep);
    trig = 1'b1;
    build(d, p2, i, p, rep);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      tick();
      e = exp_q[k];
      chk({tag, ".rf"},      16'(rf),        16'(e[0]));
      chk({tag, ".idx"},     16'(pulse_idx), 16'(e[2:1]));
      chk({tag, ".busy"},    16'(busy),      16'(e[3]));
      chk({tag, ".done"},    16'(done),      16'(e[4]));
      chk({tag, ".cfg_err"}, 16'(cfg_err),   16'd0);
`ifdef MZ_SEQ_REPEAT_EN
      chk({tag, ".shot"},    16'(shot_cnt),  16'(e[12:5]));
`endif
      if (noise && (k + 2 <= n)) begin
        trig         = 1'($urandom_range(0, 1));
        cfg_delay    = 16'($urandom_range(0, 9));
        cfg_pi2_len  = 16'($urandom_range(0, 9));
        cfg_pi_len   = 16'($urandom_range(0, 9));
        cfg_interval = 16'($urandom_range(0, 9));
`ifdef MZ_SEQ_REPEAT_EN
        cfg_repeat   = 8'($urandom_range(0, 3));
`endif
      end else begin
        trig = 1'b0;
        set_cfg(d, p2, i, p, rep);
      end
      if (stop_k >= 0 && k == stop_k) break;
    end
  endtask

  task automatic reject_check(input int p2, input int p, input string tag);
    set_cfg(3, p2, 2, p, 0);
    trig = 1'b1;
    tick();
    chk({tag, ".cfg_err"}, 16'(cfg_err), 16'd1);
    chk({tag, ".busy"},    16'(busy),    16'd0);
    chk({tag, ".rf"},      16'(rf),      16'd0);
    chk({tag, ".done"},    16'(done),    16'd0);
    trig = 1'b0;
    tick();
    chk({tag, ".cfg_err_1cyc"}, 16'(cfg_err), 16'd0);
    chk({tag, ".busy_after"},   16'(busy),    16'd0);
  endtask

  initial begin
    int rep_max;
    rst_n = 1'b1;
    trig  = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset.rf",      16'(rf),        16'd0);
    chk("reset.idx",     16'(pulse_idx), 16'd0);
    chk("reset.busy",    16'(busy),      16'd0);
    chk("reset.done",    16'(done),      16'd0);
    chk("reset.cfg_err", 16'(cfg_err),   16'd0);
`ifdef MZ_SEQ_REPEAT_EN
    chk("reset.shot",    16'(shot_cnt),  16'd0);
    rep_max = 2;
`else
    rep_max = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_seq(10, 10, 20, 20, 0, 1'b0, -1, "nominal");
    run_seq(0, 3, 0, 5, 0, 1'b0, -1, "zero_gap");

    reject_check(3, 0, "bad_pi");
    reject_check(0, 4, "bad_pi2");
    run_seq(2, 3, 2, 4, 0, 1'b0, -1, "after_bad");

    run_seq(4, 2, 3, 5, 0, 1'b1, -1, "busy_noise");

    // Reset during the pi pulse: outputs drop without waiting for a clock edge.
    run_seq(1, 2, 1, 6, 0, 1'b0, 8, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.rf",   16'(rf),        16'd0);
    chk("rst_mid.busy", 16'(busy),      16'd0);
    chk("rst_mid.idx",  16'(pulse_idx), 16'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_hold.done", 16'(done), 16'd0);
      chk("rst_hold.busy", 16'(busy), 16'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_rel.done", 16'(done), 16'd0);
    chk("rst_rel.busy", 16'(busy), 16'd0);
    run_seq(1, 2, 1, 6, 0, 1'b0, -1, "post_rst");

`ifdef MZ_SEQ_REPEAT_EN
    run_seq(2, 1, 1, 1, 2, 1'b0, -1, "repeat");
    run_seq(0, 2, 0, 1, 1, 1'b1, -1, "repeat_zero");
`endif

    for (int r = 0; r < 6; r++) begin
      run_seq($urandom_range(0, 6), $urandom_range(1, 4), $urandom_range(0, 5),
              $urandom_range(1, 6), $urandom_range(0, rep_max),
              1'($urandom_range(0, 1)), -1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
